// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM encoding for the ADC-to-UART hex
//               framer and related serial debug paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Four hex digits plus CR, LF
  localparam int FRAME_LEN = 6;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_NEXT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_to_ascii.sv
`default_nettype none
// ============================================================================
// Module      : nibble_to_ascii
// Description : Combinational 4-bit value to uppercase ASCII hex digit.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
  always_comb begin
    if (nibble <= 4'd9) begin
      ascii = ASCII_0 + {4'd0, nibble};
    end else begin
      ascii = ASCII_A + {4'd0, nibble} - 8'd10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_hex_framer.sv
`default_nettype none
// ============================================================================
// Module      : adc_hex_framer
// Description : Captures a 16-bit ADC sample on an external or periodic
//               trigger and hands it to the UART transmitter as four ASCII
//               hex digits plus CR/LF, one byte per start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_hex_framer
  import uart_pkg::*;
#(
  parameter int SAMPLE_DIV = 65536,
  parameter int TX_TIMEOUT = 32768
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample,
  input  logic        trigger,
  input  logic        auto_en,
  input  logic        tx_done,
  input  logic        clr_flags,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic [7:0]  frame_count,
  output logic        overrun,
  output logic        timeout
);

  localparam int TMR_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TX_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_shadow;
  logic [TMR_W-1:0] r_timer;
  logic [TO_W-1:0]  r_wait_cnt;

  logic             w_timer_hit;
  logic             w_trigger_any;
  logic             w_to_hit;
  logic [15:0]      w_sel_word;
  logic [IDX_W-1:0] w_sel_idx;
  logic [3:0]       w_nibble;
  logic [7:0]       w_hex;
  logic [7:0]       w_byte;

  assign w_timer_hit   = auto_en && (r_timer == c_tmr_last);
  assign w_trigger_any = trigger | w_timer_hit;
  assign w_to_hit      = (r_state == ST_WAIT) && !tx_done && (r_wait_cnt == c_to_last);

  // Byte about to be loaded: in IDLE it is byte 0 of the live sample (the
  // shadow is being written on the same edge); otherwise the next shadow byte.
  always_comb begin
    w_sel_word = (r_state == ST_IDLE) ? sample : r_shadow;
    w_sel_idx  = (r_state == ST_IDLE) ? '0 : r_idx + IDX_W'(1);
    case (w_sel_idx)
      3'd0:    w_nibble = w_sel_word[15:12];
      3'd1:    w_nibble = w_sel_word[11:8];
      3'd2:    w_nibble = w_sel_word[7:4];
      default: w_nibble = w_sel_word[3:0];
    endcase
    case (w_sel_idx)
      3'd4:    w_byte = ASCII_CR;
      3'd5:    w_byte = ASCII_LF;
      default: w_byte = w_hex;
    endcase
  end

  nibble_to_ascii u_hex (
    .nibble (w_nibble),
    .ascii  (w_hex)
  );

  // Period timer: free-runs while auto_en is high, held at zero otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!auto_en || w_timer_hit) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Sticky error flags; a new set event overrides a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (w_trigger_any && (r_state != ST_IDLE)) overrun <= 1'b1;
      else if (clr_flags)                        overrun <= 1'b0;
      if (w_to_hit)                              timeout <= 1'b1;
      else if (clr_flags)                        timeout <= 1'b0;
    end
  end

  // Frame sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_wait_cnt  <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger_any) begin
            r_shadow <= sample;
            r_idx    <= '0;
            tx_data  <= w_byte;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            r_state <= ST_NEXT;
          end else if (w_to_hit) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end
        ST_NEXT: begin
          if (r_idx == c_idx_last) begin
            frame_count <= frame_count + 8'd1;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            tx_data  <= w_byte;
            tx_start <= 1'b1;
            r_state  <= ST_START;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_hex_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_hex_framer
// Description : Self-checking bench for adc_hex_framer with a timestamp-based
//               reference model and a tx_done responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_hex_framer;

  localparam int DIV = 64;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample = '0;
  logic        trigger = 1'b0;
  logic        auto_en = 1'b0;
  logic        tx_done = 1'b0;
  logic        clr_flags = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [7:0]  frame_count;
  logic        overrun;
  logic        timeout;

  adc_hex_framer #(.SAMPLE_DIV(DIV), .TX_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample),
    .trigger     (trigger),
    .auto_en     (auto_en),
    .tx_done     (tx_done),
    .clr_flags   (clr_flags),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 byte outstanding, 2 byte done (start due next edge),
  // 3 last byte done (frame closes next edge). S = edge that raised tx_start.
  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  logic [7:0] m_frame [6];
  int   m_mode = 0, m_k = 0, m_S = 0, m_tmr = 0, edge_n = 0;
  logic       e_busy = 0, e_start = 0, e_ovr = 0, e_to = 0;
  logic [7:0] e_data = 0, e_fc = 0;

  always @(posedge clk or negedge reset_n) begin : mdl
    bit hit, trig, set_ovr, set_to;
    if (!reset_n) begin
      m_mode = 0; m_tmr = 0; m_k = 0;
      e_busy = 0; e_start = 0; e_ovr = 0; e_to = 0; e_data = 0; e_fc = 0;
    end else begin
      edge_n++;
      hit   = auto_en && (m_tmr == DIV - 1);
      m_tmr = auto_en ? (m_tmr + 1) % DIV : 0;
      trig  = trigger || hit;
      set_ovr = trig && e_busy;
      set_to  = 1'b0;
      e_start = 1'b0;
      case (m_mode)
        0: if (trig) begin
          for (int i = 0; i < 4; i++)
            m_frame[i] = hexc(int'((sample >> (12 - 4 * i)) & 16'hF));
          m_frame[4] = 8'h0D;
          m_frame[5] = 8'h0A;
          m_k = 0; m_S = edge_n; m_mode = 1;
          e_start = 1'b1; e_data = m_frame[0]; e_busy = 1'b1;
        end
        1: if (tx_done && edge_n >= m_S + 2) begin
          m_k++;
          m_mode = (m_k == 6) ? 3 : 2;
        end else if (edge_n == m_S + 1 + TMO) begin
          set_to = 1'b1; e_busy = 1'b0; m_mode = 0;
        end
        2: begin
          m_S = edge_n; e_start = 1'b1; e_data = m_frame[m_k]; m_mode = 1;
        end
        default: begin
          e_fc = e_fc + 8'd1; e_busy = 1'b0; m_mode = 0;
        end
      endcase
      e_ovr = set_ovr ? 1'b1 : (clr_flags ? 1'b0 : e_ovr);
      e_to  = set_to  ? 1'b1 : (clr_flags ? 1'b0 : e_to);
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy",        busy,        e_busy);
      chk("tx_start",    tx_start,    e_start);
      chk("tx_data",     tx_data,     e_data);
      chk("frame_count", frame_count, e_fc);
      chk("overrun",     overrun,     e_ovr);
      chk("timeout",     timeout,     e_to);
    end
  end

  // ---------------- capture and transmitter responder ----------------
  logic [7:0] cap [$];
  int resp_delay = 10, resp_cnt = 0;
  bit resp_off = 1'b0, rand_mode = 1'b0;

  always @(negedge clk) begin
    if (reset_n && tx_start) cap.push_back(tx_data);
  end

  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (reset_n && tx_start) begin
        if (resp_off || (rand_mode && $urandom_range(0, 29) == 0)) resp_cnt = 0;
        else resp_cnt = rand_mode ? int'($urandom_range(1, 12)) : resp_delay;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) tx_done = 1'b1;
      end else if (rand_mode && $urandom_range(0, 39) == 0) begin
        tx_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_trig();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle"}, busy, 0);
  endtask

  task automatic wait_cap(input string name, input int cnt, input int budget);
    int n = 0;
    while (cap.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " bytes seen"}, int'(cap.size() >= cnt), 1);
  endtask

  task automatic chk_frame(input string name, input logic [47:0] exp);
    chk({name, " count"}, cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++)
      chk({name, " byte"}, cap[i], exp[47 - 8 * i -: 8]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n, rises, bad_iv, last_rise, cyc;
    bit wrapped, pb;
    logic [7:0] pfc;

    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset frame_count", frame_count, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    cap.delete(); sample = 16'hA3F0; resp_delay = 10;
    pulse_trig();
    wait_idle("A3F0", 400, n);
    chk_frame("A3F0", 48'h4133_4630_0D0A);
    chk("A3F0 frame_count", frame_count, 1);

    // Shadow isolates the frame from sample changes
    cap.delete(); sample = 16'h0009;
    pulse_trig();
    repeat (3) @(negedge clk);
    sample = 16'hFFFF;
    wait_idle("0009", 400, n);
    chk_frame("0009", 48'h3030_3039_0D0A);
    chk("0009 frame_count", frame_count, 2);

    // Overrun while busy
    cap.delete(); sample = 16'h1234;
    pulse_trig();
    wait_cap("overrun", 2, 200);
    pulse_trig();
    chk("overrun set", overrun, 1);
    wait_idle("1234", 400, n);
    chk_frame("1234", 48'h3132_3334_0D0A);
    chk("1234 frame_count", frame_count, 3);
    pulse_clr();
    chk("overrun cleared", overrun, 0);

    // Timeout: no tx_done at all
    cap.delete(); resp_off = 1'b1; sample = 16'h7777;
    pulse_trig();
    wait_idle("timeout", 300, n);
    chk("timeout latency", n, TMO + 1);
    chk("timeout flag", timeout, 1);
    chk("timeout frame_count", frame_count, 3);
    chk("timeout bytes", cap.size(), 1);
    resp_off = 1'b0;
    cap.delete(); sample = 16'hBEEF;
    pulse_trig();
    wait_idle("BEEF", 400, n);
    chk_frame("BEEF", 48'h4245_4546_0D0A);
    chk("BEEF frame_count", frame_count, 4);
    pulse_clr();
    chk("timeout cleared", timeout, 0);

    // Asynchronous reset mid-frame
    cap.delete(); sample = 16'h5A5A;
    pulse_trig();
    wait_cap("reset", 3, 200);
    #2 reset_n = 1'b0;
    #1;
    chk("async busy", busy, 0);
    chk("async frame_count", frame_count, 0);
    @(negedge clk);
    chk("rst tx_start", tx_start, 0);
    chk("rst tx_data", tx_data, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    n = cap.size();
    repeat (30) @(negedge clk);
    chk("no start after reset", cap.size(), n);
    chk("idle after reset", busy, 0);

    // Periodic trigger and frame_count wrap
    resp_delay = 2; auto_en = 1'b1;
    rises = 0; bad_iv = 0; last_rise = 0; wrapped = 1'b0;
    pb = busy; pfc = frame_count;
    for (cyc = 0; cyc < 256 * DIV + 300 && !wrapped; cyc++) begin
      @(negedge clk);
      if (!pb && busy) begin
        if (rises > 0 && cyc - last_rise != DIV) bad_iv++;
        rises++;
        last_rise = cyc;
      end
      if (pfc == 8'd255 && frame_count == 8'd0) wrapped = 1'b1;
      pb = busy; pfc = frame_count;
    end
    chk("auto wrap seen", wrapped, 1);
    chk("auto frames", rises, 256);
    chk("auto period errors", bad_iv, 0);
    auto_en = 1'b0;
    wait_idle("auto", 200, n);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      trigger   = ($urandom_range(0, 24) == 0);
      sample    = 16'($urandom);
      clr_flags = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) auto_en = ~auto_en;
    end
    trigger = 1'b0; clr_flags = 1'b0; auto_en = 1'b0; rand_mode = 1'b0;
    wait_idle("random", 400, n);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
